// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with independent TX and RX state machines sharing one clock.
// Bit timing comes from a fixed clocks-per-bit divider; data is sent LSB first.
`timescale 1ns/1ps

module uart_transceiver #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);
    // state   | meaning
    // IDLE    | line high, waiting for a TX strobe / RX falling edge
    // START   | start bit (RX: counting to the bit centre)
    // DATA    | eight data bits, LSB first
    // STOP    | stop bit (RX: waits here on a framing error until line is high)
    // CLEANUP | single cycle before returning to IDLE
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_t;

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    state_t        tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_idx, tx_idx_nxt;
    logic [7:0]    tx_data, tx_data_nxt;
    logic          tx_serial_nxt, tx_active_nxt, tx_done_nxt;
    logic [2:0]    tx_idx_inc;

    assign tx_idx_inc = tx_idx + 3'd1;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_data     <= '0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            tx_state    <= tx_state_nxt;
            tx_cnt      <= tx_cnt_nxt;
            tx_idx      <= tx_idx_nxt;
            tx_data     <= tx_data_nxt;
            o_TX_Serial <= tx_serial_nxt;
            o_TX_Active <= tx_active_nxt;
            o_TX_Done   <= tx_done_nxt;
        end
    end

    always_comb begin
        tx_state_nxt  = tx_state;
        tx_cnt_nxt    = tx_cnt;
        tx_idx_nxt    = tx_idx;
        tx_data_nxt   = tx_data;
        tx_serial_nxt = o_TX_Serial;
        tx_active_nxt = o_TX_Active;
        tx_done_nxt   = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_serial_nxt = 1'b1;
                tx_active_nxt = 1'b0;
                tx_cnt_nxt    = '0;
                tx_idx_nxt    = '0;
                if (i_TX_DV) begin
                    tx_data_nxt   = i_TX_Byte;
                    tx_state_nxt  = S_START;
                    tx_serial_nxt = 1'b0;
                    tx_active_nxt = 1'b1;
                end
            end
            S_START: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_nxt    = '0;
                    tx_state_nxt  = S_DATA;
                    tx_serial_nxt = tx_data[0];
                end else begin
                    tx_cnt_nxt = tx_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_idx == 3'd7) begin
                        tx_idx_nxt    = '0;
                        tx_state_nxt  = S_STOP;
                        tx_serial_nxt = 1'b1;
                    end else begin
                        tx_idx_nxt    = tx_idx_inc;
                        tx_serial_nxt = tx_data[tx_idx_inc];
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_nxt    = '0;
                    tx_done_nxt   = 1'b1;
                    tx_active_nxt = 1'b0;
                    tx_state_nxt  = S_CLEANUP;
                end else begin
                    tx_cnt_nxt = tx_cnt + CW'(1);
                end
            end
            S_CLEANUP: tx_state_nxt = S_IDLE;
            default:   tx_state_nxt = S_IDLE;
        endcase
    end

    // The RX pin is asynchronous; only rx_sync is ever used by the FSM.
    logic rx_meta, rx_sync;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_sync <= rx_meta;
        end
    end

    state_t        rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_idx, rx_idx_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;
    logic [7:0]    rx_byte_nxt;
    logic          rx_dv_nxt;
    logic          rx_ferr, rx_ferr_nxt;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_shift  <= '0;
            rx_ferr   <= 1'b0;
            o_RX_Byte <= 8'h00;
            o_RX_DV   <= 1'b0;
        end else begin
            rx_state  <= rx_state_nxt;
            rx_cnt    <= rx_cnt_nxt;
            rx_idx    <= rx_idx_nxt;
            rx_shift  <= rx_shift_nxt;
            rx_ferr   <= rx_ferr_nxt;
            o_RX_Byte <= rx_byte_nxt;
            o_RX_DV   <= rx_dv_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        rx_ferr_nxt  = rx_ferr;
        rx_byte_nxt  = o_RX_Byte;
        rx_dv_nxt    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_nxt  = '0;
                rx_idx_nxt  = '0;
                rx_ferr_nxt = 1'b0;
                if (!rx_sync) rx_state_nxt = S_START;
            end
            S_START: begin
                if (rx_cnt == HALF) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_nxt           = '0;
                    rx_shift_nxt[rx_idx] = rx_sync;
                    if (rx_idx == 3'd7) begin
                        rx_idx_nxt   = '0;
                        rx_state_nxt = S_STOP;
                    end else begin
                        rx_idx_nxt = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CW'(1);
                end
            end
            S_STOP: begin
                // Counter parks at LAST on a framing error until the line recovers.
                if (rx_cnt != LAST) begin
                    rx_cnt_nxt = rx_cnt + CW'(1);
                end else if (rx_sync) begin
                    if (!rx_ferr) begin
                        rx_byte_nxt = rx_shift;
                        rx_dv_nxt   = 1'b1;
                    end
                    rx_ferr_nxt  = 1'b0;
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = S_CLEANUP;
                end else begin
                    rx_ferr_nxt = 1'b1;
                end
            end
            S_CLEANUP: rx_state_nxt = S_IDLE;
            default:   rx_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: loopback, back-to-back, glitch, framing error and mid-frame reset,
// with random bytes checked against a frame-level reference model.
`timescale 1ns/1ps

module tb_uart_transceiver;
    localparam int CPB = 217;

    logic       clk;
    logic       rst_n;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active, tx_serial, tx_done;
    logic       rx_line, rx_dv;
    logic [7:0] rx_byte;
    logic       loopback, tb_rx;

    assign rx_line = loopback ? tx_serial : tb_rx;

    uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock    (clk),
        .i_Rst_n    (rst_n),
        .i_TX_DV    (tx_dv),
        .i_TX_Byte  (tx_byte),
        .o_TX_Active(tx_active),
        .o_TX_Serial(tx_serial),
        .o_TX_Done  (tx_done),
        .i_RX_Serial(rx_line),
        .o_RX_DV    (rx_dv),
        .o_RX_Byte  (rx_byte)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    int n_vec = 0;
    int n_fail = 0;
    int dv_count = 0;
    int done_count = 0;
    int exp_dv = 0;
    int exp_done = 0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (rx_dv === 1'b1) begin
            dv_count <= dv_count + 1;
            last_rx  <= rx_byte;
        end
        if (tx_done === 1'b1) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmit one frame and check the line at every bit centre plus Done/Active timing.
    task automatic send_frame(input logic [7:0] b, input bit intrude);
        logic [9:0] frame;
        int t;
        frame = {1'b1, b, 1'b0};
        exp_q.push_back(b);
        exp_done++;
        tx_dv   = 1'b1;
        tx_byte = b;
        @(posedge clk);
        #1 tx_dv = 1'b0;
        t = 0;
        for (int k = 0; k < 10; k++) begin
            int target;
            target = k * CPB + CPB / 2;
            repeat (target - t) @(posedge clk);
            t = target;
            #1;
            check("tx_bit", {31'd0, tx_serial}, {31'd0, frame[k]});
            if (k == 0) check("tx_active", {31'd0, tx_active}, 32'd1);
            if (intrude && k == 4) begin
                tx_dv   = 1'b1;
                tx_byte = 8'h5A;
                @(posedge clk);
                t++;
                #1 tx_dv = 1'b0;
            end
        end
        repeat (10 * CPB - 1 - t) @(posedge clk);
        #1;
        check("tx_done_early", {31'd0, tx_done}, 32'd0);
        @(posedge clk);
        #1;
        check("tx_done_pulse", {31'd0, tx_done}, 32'd1);
        check("tx_active_drop", {31'd0, tx_active}, 32'd0);
        @(posedge clk);
        #1;
        check("tx_done_clear", {31'd0, tx_done}, 32'd0);
        check("tx_done_count", done_count, exp_done);
    endtask

    // Drive a frame onto the RX pin directly; a good stop bit means the model expects the byte.
    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        if (stop_bit) exp_q.push_back(b);
        for (int k = 0; k < 10; k++) begin
            tb_rx = frame[k];
            repeat (CPB) @(posedge clk);
            #1;
        end
        tb_rx = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic expect_rx();
        logic [7:0] eb;
        int w;
        eb = exp_q.pop_front();
        exp_dv++;
        w = 0;
        while (dv_count < exp_dv && w < 4 * CPB) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("rx_dv_count", dv_count, exp_dv);
        check("rx_byte", {24'd0, last_rx}, {24'd0, eb});
    endtask

    initial begin
        logic [7:0] rb;
        rst_n    = 1'b0;
        tx_dv    = 1'b0;
        tx_byte  = 8'h00;
        tb_rx    = 1'b1;
        loopback = 1'b1;

        repeat (5) @(posedge clk);
        #1;
        check("rst_tx_serial", {31'd0, tx_serial}, 32'd1);
        check("rst_tx_active", {31'd0, tx_active}, 32'd0);
        check("rst_tx_done", {31'd0, tx_done}, 32'd0);
        check("rst_rx_dv", {31'd0, rx_dv}, 32'd0);
        check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send_frame(8'h3F, 1'b0);
        expect_rx();

        send_frame(8'h00, 1'b1);
        expect_rx();
        send_frame(8'hFF, 1'b0);
        expect_rx();
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("no_extra_frame", done_count, exp_done);
        check("no_extra_rx", dv_count, exp_dv);

        loopback = 1'b0;
        tb_rx    = 1'b0;
        repeat (50) @(posedge clk);
        #1 tb_rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("glitch_no_dv", dv_count, exp_dv);
        drive_rx(8'hA5, 1'b1);
        expect_rx();

        drive_rx(8'h55, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("ferr_no_dv", dv_count, exp_dv);
        check("ferr_byte_held", {24'd0, rx_byte}, 32'hA5);

        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            drive_rx(rb, 1'b1);
            expect_rx();
        end

        loopback = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tx_dv   = 1'b1;
        tx_byte = 8'hC3;
        @(posedge clk);
        #1 tx_dv = 1'b0;
        repeat (4 * CPB + CPB / 2) @(posedge clk);
        #1;
        check("pre_rst_bit3", {31'd0, tx_serial}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_serial", {31'd0, tx_serial}, 32'd1);
        check("midrst_active", {31'd0, tx_active}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("midrst_no_done", done_count, exp_done);
        check("midrst_no_dv", dv_count, exp_dv);
        send_frame(8'h96, 1'b0);
        expect_rx();

        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, 1'b0);
            expect_rx();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
